// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline sequencing beside the ID stage of the 5-stage MIPS core.
// Detects load-use hazards, flushes on taken branches, runs the multi-cycle mult/div
// sequencer and stalls the front end while HI/LO are busy. Control outputs are
// combinational in the same cycle; MD_Busy/MD_Done decode the registered FSM state.
// Ports:
//   clk, rst                      - core clock, synchronous active-high reset
//   ID_Rs, ID_Rt, ID_Uses_Rt      - source fields of the instruction in ID
//   EX_MemRead, EX_Rt             - load in EX and its destination register
//   Branch_Taken_EX               - taken branch/jump resolved in EX
//   MD_Start, MD_Is_Div           - mult/div issue from ID, divide qualifier
//   ID_Reads_HiLo                 - mfhi/mflo in ID
//   PC_Write, IF_ID_Write         - front-end enables
//   IF_ID_Flush, ID_EX_Bubble     - squash controls
//   MD_Busy, MD_Done              - mult/div unit status
//   Stall_Count                   - saturating count of stalled cycles
module hazard_stall_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic              ID_Uses_Rt,
  input  logic              EX_MemRead,
  input  logic [4:0]        EX_Rt,
  input  logic              Branch_Taken_EX,
  input  logic              MD_Start,
  input  logic              MD_Is_Div,
  input  logic              ID_Reads_HiLo,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Bubble,
  output logic              MD_Busy,
  output logic              MD_Done,
  output logic [PERF_W-1:0] Stall_Count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu, st, stall, md_accept;

  // $0 is hardwired zero, so a load "to $0" never creates a dependency.
  assign lu = EX_MemRead && (EX_Rt != 5'd0) &&
              ((EX_Rt == ID_Rs) || (ID_Uses_Rt && (EX_Rt == ID_Rt)));
  assign st = (state == BUSY) && (MD_Start || ID_Reads_HiLo);

  // A taken branch overrides any stall: the ID instruction is on the wrong path.
  assign stall     = !Branch_Taken_EX && (lu || st);
  // A start is only taken outside BUSY (in BUSY it is held by st instead).
  assign md_accept = MD_Start && !Branch_Taken_EX && !lu;

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    if (rst) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (Branch_Taken_EX) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (stall) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

  // Gated by rst so a reset taken mid-operation drops status in the same cycle.
  assign MD_Busy = !rst && (state == BUSY);
  assign MD_Done = !rst && (state == DONE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      BUSY: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      IDLE, DONE: begin
        if (md_accept) begin
          state_nxt = BUSY;
          cnt_nxt   = MD_Is_Div ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      Stall_Count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall && (Stall_Count != {PERF_W{1'b1}}))
        Stall_Count <= Stall_Count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;
  localparam int PERF_W = 4;
  localparam int SAT    = (1 << PERF_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ID_Rs, ID_Rt, EX_Rt;
  logic ID_Uses_Rt, EX_MemRead, Branch_Taken_EX, MD_Start, MD_Is_Div, ID_Reads_HiLo;
  logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MD_Busy, MD_Done;
  logic [PERF_W-1:0] Stall_Count;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_stall_controller #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Uses_Rt(ID_Uses_Rt),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .Branch_Taken_EX(Branch_Taken_EX),
    .MD_Start(MD_Start), .MD_Is_Div(MD_Is_Div), .ID_Reads_HiLo(ID_Reads_HiLo),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .MD_Busy(MD_Busy), .MD_Done(MD_Done),
    .Stall_Count(Stall_Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining busy cycles, a done flag and a stall tally.
  int m_left = 0;
  bit m_done = 1'b0;
  int m_stalls = 0;

  function automatic bit m_lu();
    return EX_MemRead && EX_Rt != 0 &&
           (EX_Rt == ID_Rs || (ID_Uses_Rt && EX_Rt == ID_Rt));
  endfunction

  function automatic bit m_stall();
    return !Branch_Taken_EX && (m_lu() || (m_left > 0 && (MD_Start || ID_Reads_HiLo)));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_stalls = 0;
    end else begin
      if (m_stall()) m_stalls = (m_stalls < SAT) ? m_stalls + 1 : SAT;
      if (m_left > 0) begin
        m_left = m_left - 1;
        m_done = (m_left == 0);
      end else begin
        m_done = 1'b0;
        if (MD_Start && !Branch_Taken_EX && !m_lu()) m_left = MD_Is_Div ? 32 : 4;
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    int e_pc, e_ifw, e_fl, e_bub;
    if (rst) begin
      e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
    end else if (Branch_Taken_EX) begin
      e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 1;
    end else if (m_stall()) begin
      e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1;
    end else begin
      e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0;
    end
    chk("m_pc_write",   int'(PC_Write),     e_pc);
    chk("m_if_id_write", int'(IF_ID_Write), e_ifw);
    chk("m_if_id_flush", int'(IF_ID_Flush), e_fl);
    chk("m_id_ex_bubble", int'(ID_EX_Bubble), e_bub);
    chk("m_md_busy",    int'(MD_Busy),      (!rst && m_left > 0) ? 1 : 0);
    chk("m_md_done",    int'(MD_Done),      (!rst && m_done) ? 1 : 0);
    chk("m_stall_count", int'(Stall_Count), m_stalls);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic idle_in();
    ID_Rs = 5'd1; ID_Rt = 5'd2; ID_Uses_Rt = 1'b0; EX_MemRead = 1'b0; EX_Rt = 5'd0;
    Branch_Taken_EX = 1'b0; MD_Start = 1'b0; MD_Is_Div = 1'b0; ID_Reads_HiLo = 1'b0;
  endtask

  initial begin
    int busy_n, done_n;
    rst = 1'b1;
    idle_in();
    MD_Start = 1'b1;

    // Reset held two cycles with MD_Start asserted.
    tick(); tick();
    mid();
    chk("rst_pc_write", int'(PC_Write), 0);
    chk("rst_flush", int'(IF_ID_Flush), 1);
    chk("rst_bubble", int'(ID_EX_Bubble), 1);
    chk("rst_md_busy", int'(MD_Busy), 0);
    chk("rst_stall_count", int'(Stall_Count), 0);
    tick();
    rst = 1'b0; idle_in();
    mid();
    chk("post_rst_pc_write", int'(PC_Write), 1);
    chk("post_rst_if_id_write", int'(IF_ID_Write), 1);

    // Load-use on rs.
    tick();
    EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
    mid();
    chk("lu_pc_write", int'(PC_Write), 0);
    chk("lu_if_id_write", int'(IF_ID_Write), 0);
    chk("lu_bubble", int'(ID_EX_Bubble), 1);
    tick();
    idle_in();
    mid();
    chk("lu_stall_count", int'(Stall_Count), 1);

    // Load to $0 never stalls.
    tick();
    EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0;
    mid();
    chk("r0_pc_write", int'(PC_Write), 1);

    // rt match without rt use does not stall; with use it does.
    tick();
    EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd3; ID_Rt = 5'd8; ID_Uses_Rt = 1'b0;
    mid();
    chk("rt_unused_pc_write", int'(PC_Write), 1);
    tick();
    ID_Uses_Rt = 1'b1;
    mid();
    chk("rt_used_pc_write", int'(PC_Write), 0);
    tick();   // count now 2

    // Branch priority over load-use and MD_Start.
    idle_in();
    EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8; MD_Start = 1'b1; Branch_Taken_EX = 1'b1;
    mid();
    chk("br_flush", int'(IF_ID_Flush), 1);
    chk("br_bubble", int'(ID_EX_Bubble), 1);
    chk("br_pc_write", int'(PC_Write), 1);
    tick();
    idle_in();
    mid();
    chk("br_md_busy", int'(MD_Busy), 0);
    chk("br_stall_count", int'(Stall_Count), 2);

    // Multiply, mflo waiting behind it.
    tick();
    MD_Start = 1'b1; MD_Is_Div = 1'b0;
    mid();
    chk("mul_issue_pc_write", int'(PC_Write), 1);
    tick();
    MD_Start = 1'b0; ID_Reads_HiLo = 1'b1;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 8; i++) begin
      mid();
      if (MD_Busy) busy_n++;
      if (MD_Done) begin
        done_n++;
        chk("mul_done_hilo_passes", int'(PC_Write), 1);
      end
      tick();
    end
    chk("mul_busy_cycles", busy_n, 4);
    chk("mul_done_cycles", done_n, 1);
    idle_in();
    mid();
    chk("mul_stall_count", int'(Stall_Count), 6);

    // Saturation: 20 consecutive stalls.
    EX_MemRead = 1'b1; EX_Rt = 5'd9; ID_Rs = 5'd9;
    for (int i = 0; i < 20; i++) tick();
    idle_in();
    mid();
    chk("sat_stall_count", int'(Stall_Count), SAT);

    // Divide aborted by reset at busy cycle 10.
    tick();
    MD_Start = 1'b1; MD_Is_Div = 1'b1;
    tick();
    idle_in();
    busy_n = 0;
    for (int i = 0; i < 9; i++) begin
      mid();
      if (MD_Busy) busy_n++;
      tick();
    end
    mid();
    if (MD_Busy) busy_n++;
    chk("div_busy_before_abort", busy_n, 10);
    tick();
    rst = 1'b1;
    tick();
    mid();
    chk("abort_md_busy", int'(MD_Busy), 0);
    tick();
    rst = 1'b0;
    done_n = 0; busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      mid();
      if (MD_Done) done_n++;
      if (MD_Busy) busy_n++;
      tick();
    end
    chk("abort_no_done", done_n, 0);
    chk("abort_no_busy", busy_n, 0);
    chk("abort_stall_count", int'(Stall_Count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
